// File: rtl/gemm_ctrl_if.sv
// ============================================================================
//  Module      : gemm_ctrl_if
//  Description : Decoder-side and buffer-side signal bundle for gemm_ctrl.
//                master = instruction decoder / environment,
//                slave  = the gemm_ctrl sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gemm_ctrl_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
);
  // Decoder side: launch and tile configuration
  logic                  start;
  logic [CNT_WIDTH-1:0]  cfg_num_k;
  logic [CNT_WIDTH-1:0]  cfg_num_ocp;
  logic [ADDR_WIDTH-1:0] cfg_inp_base;
  logic [ADDR_WIDTH-1:0] cfg_wgt_base;
  logic [ADDR_WIDTH-1:0] cfg_acc_base;
  logic                  busy;
  logic                  done;

  // Buffer / GEMM side
  logic                  inp_rd_en;
  logic [ADDR_WIDTH-1:0] inp_rd_addr;
  logic                  wgt_rd_en;
  logic [ADDR_WIDTH-1:0] wgt_rd_addr;
  logic                  acc_rd_en;
  logic [ADDR_WIDTH-1:0] acc_rd_addr;
  logic                  acc_zero;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;

  modport master (
    output start, cfg_num_k, cfg_num_ocp, cfg_inp_base, cfg_wgt_base, cfg_acc_base,
    input  busy, done, inp_rd_en, inp_rd_addr, wgt_rd_en, wgt_rd_addr,
           acc_rd_en, acc_rd_addr, acc_zero, wr_en, wr_addr
  );

  modport slave (
    input  start, cfg_num_k, cfg_num_ocp, cfg_inp_base, cfg_wgt_base, cfg_acc_base,
    output busy, done, inp_rd_en, inp_rd_addr, wgt_rd_en, wgt_rd_addr,
           acc_rd_en, acc_rd_addr, acc_zero, wr_en, wr_addr
  );
endinterface

`default_nettype wire

// File: rtl/gemm_ctrl.sv
// ============================================================================
//  Module      : gemm_ctrl
//  Description : Tile sequencer for the paired-output GEMM datapath. Walks
//                num_k (outer) x num_ocp (inner) issue slots, drives input /
//                weight / accumulator read addresses, and produces the
//                acc_zero and write-back strobes aligned to the 1-cycle
//                buffer latency and 1-cycle GEMM latency.
//                Optional feature macro: GEMM_CTRL_PERF_EN adds the
//                perf_busy_cycles / perf_bubbles saturating counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gemm_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  wire logic       clk,
  input  wire logic       rst,
  gemm_ctrl_if.slave      bus
`ifdef GEMM_CTRL_PERF_EN
  ,
  output logic [31:0]     perf_busy_cycles,
  output logic [15:0]     perf_bubbles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_BUBBLE = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0] C_CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] C_CNT_THREE = CNT_WIDTH'(3);

  state_t                r_state;
  state_t                w_next;

  // Latched tile configuration
  logic [CNT_WIDTH-1:0]  r_num_k;
  logic [CNT_WIDTH-1:0]  r_num_ocp;
  logic [ADDR_WIDTH-1:0] r_inp_base;
  logic [ADDR_WIDTH-1:0] r_acc_base;

  // Loop position; the weight address simply advances once per slot because
  // wgt_base + k*num_ocp + ocp is a linear walk in k-outer / ocp-inner order.
  logic [CNT_WIDTH-1:0]  r_k;
  logic [CNT_WIDTH-1:0]  r_ocp;
  logic [ADDR_WIDTH-1:0] r_wgt_addr;
  logic [1:0]            r_cnt;      // bubble / drain cycle counter

  // Write-back alignment pipeline
  logic                  r_acc_zero;
  logic                  r_wr_p1;
  logic                  r_wr_p2;
  logic [ADDR_WIDTH-1:0] r_wr_addr_p1;
  logic [ADDR_WIDTH-1:0] r_wr_addr_p2;

  logic                  w_issue;
  logic                  w_accept;
  logic                  w_zero_cfg;
  logic                  w_last_ocp;
  logic                  w_last_k;
  logic                  w_short;
  logic                  w_bub_last;
  logic [ADDR_WIDTH-1:0] w_acc_addr;

  assign w_issue    = (r_state == S_ISSUE);
  assign w_accept   = (r_state == S_IDLE) && bus.start;
  assign w_zero_cfg = (bus.cfg_num_k == '0) || (bus.cfg_num_ocp == '0);
  assign w_last_ocp = (r_ocp == r_num_ocp - C_CNT_ONE);
  assign w_last_k   = (r_k == r_num_k - C_CNT_ONE);
  // Fewer than 3 ocp per k would re-read an acc address before its write-back
  // lands, so short rows are padded out to 3 cycles with bubbles.
  assign w_short    = (r_num_ocp < C_CNT_THREE);
  // Bubble length is 3 - num_ocp: two cycles for num_ocp==1, one for num_ocp==2.
  assign w_bub_last = (r_num_ocp == C_CNT_ONE) ? (r_cnt == 2'd1) : 1'b1;
  assign w_acc_addr = r_acc_base + ADDR_WIDTH'(r_ocp);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = w_zero_cfg ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (w_last_ocp) begin
          if (w_last_k) begin
            w_next = S_DRAIN;
          end else if (w_short) begin
            w_next = S_BUBBLE;
          end
        end
      end
      S_BUBBLE: begin
        if (w_bub_last) begin
          w_next = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (r_cnt == 2'd1) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Configuration latch and loop counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_num_k    <= '0;
      r_num_ocp  <= '0;
      r_inp_base <= '0;
      r_acc_base <= '0;
      r_wgt_addr <= '0;
      r_k        <= '0;
      r_ocp      <= '0;
      r_cnt      <= '0;
    end else if (w_accept) begin
      r_num_k    <= bus.cfg_num_k;
      r_num_ocp  <= bus.cfg_num_ocp;
      r_inp_base <= bus.cfg_inp_base;
      r_acc_base <= bus.cfg_acc_base;
      r_wgt_addr <= bus.cfg_wgt_base;
      r_k        <= '0;
      r_ocp      <= '0;
      r_cnt      <= '0;
    end else if (w_issue) begin
      r_wgt_addr <= r_wgt_addr + ADDR_WIDTH'(1);
      if (w_last_ocp) begin
        r_ocp <= '0;
        r_cnt <= '0;
        if (!w_last_k) begin
          r_k <= r_k + C_CNT_ONE;
        end
      end else begin
        r_ocp <= r_ocp + C_CNT_ONE;
      end
    end else if ((r_state == S_BUBBLE) || (r_state == S_DRAIN)) begin
      r_cnt <= r_cnt + 2'd1;
    end
  end

  // Align acc_zero (t+1) and write-back (t+2) with each issue slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc_zero   <= 1'b0;
      r_wr_p1      <= 1'b0;
      r_wr_p2      <= 1'b0;
      r_wr_addr_p1 <= '0;
      r_wr_addr_p2 <= '0;
    end else begin
      r_acc_zero   <= w_issue && (r_k == '0);
      r_wr_p1      <= w_issue;
      r_wr_p2      <= r_wr_p1;
      r_wr_addr_p1 <= w_issue ? w_acc_addr : '0;
      r_wr_addr_p2 <= r_wr_addr_p1;
    end
  end

  // Output drive; read addresses are held at zero outside issue slots
  always_comb begin
    bus.busy        = (r_state != S_IDLE);
    bus.done        = (r_state == S_DONE);
    bus.inp_rd_en   = w_issue;
    bus.inp_rd_addr = w_issue ? (r_inp_base + ADDR_WIDTH'(r_k)) : '0;
    bus.wgt_rd_en   = w_issue;
    bus.wgt_rd_addr = w_issue ? r_wgt_addr : '0;
    bus.acc_rd_en   = w_issue && (r_k != '0);
    bus.acc_rd_addr = w_issue ? w_acc_addr : '0;
    bus.acc_zero    = r_acc_zero;
    bus.wr_en       = r_wr_p2;
    bus.wr_addr     = r_wr_addr_p2;
  end

`ifdef GEMM_CTRL_PERF_EN
  logic [31:0] r_perf_busy;
  logic [15:0] r_perf_bub;

  // Saturating busy / bubble cycle counters, restarted by each accepted start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_busy <= '0;
      r_perf_bub  <= '0;
    end else if (w_accept) begin
      r_perf_busy <= '0;
      r_perf_bub  <= '0;
    end else begin
      if ((r_state != S_IDLE) && !(&r_perf_busy)) begin
        r_perf_busy <= r_perf_busy + 32'd1;
      end
      if ((r_state == S_BUBBLE) && !(&r_perf_bub)) begin
        r_perf_bub <= r_perf_bub + 16'd1;
      end
    end
  end

  assign perf_busy_cycles = r_perf_busy;
  assign perf_bubbles     = r_perf_bub;
`else
`endif

endmodule

`default_nettype wire

// File: tb/tb_gemm_ctrl.sv
// ============================================================================
//  Module      : tb_gemm_ctrl
//  Description : Directed self-checking bench for gemm_ctrl. Cycle n is the
//                interval after the n-th rising edge following the start
//                cycle (cycle 0); outputs are sampled 1 time unit after edges.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gemm_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  gemm_ctrl_if #(.ADDR_WIDTH(8), .CNT_WIDTH(8)) bus ();

`ifdef GEMM_CTRL_PERF_EN
  logic [31:0] perf_busy_cycles;
  logic [15:0] perf_bubbles;
`endif

  gemm_ctrl #(.ADDR_WIDTH(8), .CNT_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef GEMM_CTRL_PERF_EN
    ,
    .perf_busy_cycles (perf_busy_cycles),
    .perf_bubbles     (perf_bubbles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s@c%0d: observed %0h expected %0h", tag, c, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int c,
                            input int e_iss, input int e_inp_a, input int e_wgt_a,
                            input int e_acc_en, input int e_acc_a, input int e_az,
                            input int e_wr, input int e_wr_a, input int e_busy, input int e_done);
    chk({tag, " inp_rd_en"},   c, 32'(bus.inp_rd_en),   32'(e_iss));
    chk({tag, " inp_rd_addr"}, c, 32'(bus.inp_rd_addr), 32'(e_inp_a));
    chk({tag, " wgt_rd_en"},   c, 32'(bus.wgt_rd_en),   32'(e_iss));
    chk({tag, " wgt_rd_addr"}, c, 32'(bus.wgt_rd_addr), 32'(e_wgt_a));
    chk({tag, " acc_rd_en"},   c, 32'(bus.acc_rd_en),   32'(e_acc_en));
    chk({tag, " acc_rd_addr"}, c, 32'(bus.acc_rd_addr), 32'(e_acc_a));
    chk({tag, " acc_zero"},    c, 32'(bus.acc_zero),    32'(e_az));
    chk({tag, " wr_en"},       c, 32'(bus.wr_en),       32'(e_wr));
    chk({tag, " wr_addr"},     c, 32'(bus.wr_addr),     32'(e_wr_a));
    chk({tag, " busy"},        c, 32'(bus.busy),        32'(e_busy));
    chk({tag, " done"},        c, 32'(bus.done),        32'(e_done));
  endtask

  // Basic tile: num_k=2, num_ocp=4, bases 0x10/0x20/0x40. Caller is in cycle 0.
  task automatic run_basic(input string tag);
    int iss, wr;
    bus.cfg_num_k    = 8'd2;
    bus.cfg_num_ocp  = 8'd4;
    bus.cfg_inp_base = 8'h10;
    bus.cfg_wgt_base = 8'h20;
    bus.cfg_acc_base = 8'h40;
    bus.start        = 1'b1;
    tick();
    bus.start        = 1'b0;
    // Scramble configuration to confirm it was latched at start
    bus.cfg_num_k    = 8'd7;
    bus.cfg_num_ocp  = 8'd1;
    bus.cfg_inp_base = 8'hA0;
    bus.cfg_wgt_base = 8'hB0;
    bus.cfg_acc_base = 8'hC0;
    for (int c = 1; c <= 12; c++) begin
      iss = (c >= 1 && c <= 8) ? 1 : 0;
      wr  = (c >= 3 && c <= 10) ? 1 : 0;
      check_outs(tag, c, iss,
                 iss ? (8'h10 + ((c >= 5) ? 1 : 0)) : 0,
                 iss ? (8'h20 + c - 1) : 0,
                 (c >= 5 && c <= 8) ? 1 : 0,
                 iss ? (8'h40 + ((c - 1) % 4)) : 0,
                 (c >= 2 && c <= 5) ? 1 : 0,
                 wr, wr ? (8'h40 + ((c - 3) % 4)) : 0,
                 (c <= 11) ? 1 : 0, (c == 11) ? 1 : 0);
      tick();
    end
  endtask

  initial begin
    int iss, wr;
    checks = 0;
    errors = 0;
    rst              = 1'b1;
    bus.start        = 1'b0;
    bus.cfg_num_k    = '0;
    bus.cfg_num_ocp  = '0;
    bus.cfg_inp_base = '0;
    bus.cfg_wgt_base = '0;
    bus.cfg_acc_base = '0;

    // Reset state
    tick();
    check_outs("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef GEMM_CTRL_PERF_EN
    chk("reset perf_busy", 0, perf_busy_cycles, 32'd0);
    chk("reset perf_bub",  0, 32'(perf_bubbles), 32'd0);
`endif
    tick();
    rst = 1'b0;
    tick();

    // Basic tile
    run_basic("basic");

    // Bubble tile: num_k=3, num_ocp=1; issues 1,4,7; writes 3,6,9; done 10
    bus.cfg_num_k    = 8'd3;
    bus.cfg_num_ocp  = 8'd1;
    bus.cfg_inp_base = 8'h05;
    bus.cfg_wgt_base = 8'h80;
    bus.cfg_acc_base = 8'h30;
    bus.start        = 1'b1;
    tick();
    bus.start        = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      iss = (c == 1 || c == 4 || c == 7) ? 1 : 0;
      wr  = (c == 3 || c == 6 || c == 9) ? 1 : 0;
      check_outs("bubble", c, iss,
                 iss ? (8'h05 + (c - 1) / 3) : 0,
                 iss ? (8'h80 + (c - 1) / 3) : 0,
                 (iss && c > 1) ? 1 : 0,
                 iss ? 8'h30 : 0,
                 (c == 2) ? 1 : 0,
                 wr, wr ? 8'h30 : 0,
                 (c <= 10) ? 1 : 0, (c == 10) ? 1 : 0);
      if (c == 11) begin
`ifdef GEMM_CTRL_PERF_EN
        chk("bubble perf_busy", c, perf_busy_cycles, 32'd10);
        chk("bubble perf_bub",  c, 32'(perf_bubbles), 32'd4);
`endif
        // Back-to-back: zero-count start on the cycle after done
        bus.cfg_num_k   = 8'd0;
        bus.cfg_num_ocp = 8'd5;
        bus.start       = 1'b1;
      end
      tick();
    end
    bus.start = 1'b0;

    // Zero-count tile: busy and done at cycle 1 only, no enables
    for (int c = 1; c <= 3; c++) begin
      check_outs("zero", c, 0, 0, 0, 0, 0, 0, 0, 0,
                 (c == 1) ? 1 : 0, (c == 1) ? 1 : 0);
`ifdef GEMM_CTRL_PERF_EN
      if (c == 3) begin
        chk("zero perf_busy", c, perf_busy_cycles, 32'd1);
        chk("zero perf_bub",  c, 32'(perf_bubbles), 32'd0);
      end
`endif
      tick();
    end

    // Address wrap with an ignored start pulse at cycle 2
    bus.cfg_num_k    = 8'd1;
    bus.cfg_num_ocp  = 8'd3;
    bus.cfg_inp_base = 8'h00;
    bus.cfg_wgt_base = 8'h00;
    bus.cfg_acc_base = 8'hFE;
    bus.start        = 1'b1;
    tick();
    bus.start        = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      iss = (c <= 3) ? 1 : 0;
      wr  = (c >= 3 && c <= 5) ? 1 : 0;
      check_outs("wrap", c, iss, 0,
                 iss ? (c - 1) : 0,
                 0,
                 iss ? ((8'hFE + c - 1) & 8'hFF) : 0,
                 (c >= 2 && c <= 4) ? 1 : 0,
                 wr, wr ? ((8'hFE + c - 3) & 8'hFF) : 0,
                 (c <= 6) ? 1 : 0, (c == 6) ? 1 : 0);
      bus.start = (c == 2) ? 1'b1 : 1'b0;
      tick();
    end
    bus.start = 1'b0;

    // Reset mid-tile at cycle 4 of the basic tile
    bus.cfg_num_k    = 8'd2;
    bus.cfg_num_ocp  = 8'd4;
    bus.cfg_inp_base = 8'h10;
    bus.cfg_wgt_base = 8'h20;
    bus.cfg_acc_base = 8'h40;
    bus.start        = 1'b1;
    tick();
    bus.start        = 1'b0;
    tick();
    tick();
    tick();
    check_outs("pre_rst", 4, 1, 8'h10, 8'h23, 0, 8'h43, 1, 1, 8'h41, 1, 0);
    rst = 1'b1;
    #1;
    check_outs("mid_rst", 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_outs("post_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_basic("rerun");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
